// File: rtl/age_matrix_issue_queue.sv
// Unified reservation station. Entries are tracked with a full age matrix:
// the oldest ready entries are issued first, independent of slot index and
// ROB number. Supports same-cycle wakeup bypass on dispatch, full flush and
// partial kill of entries younger than a branch.
module age_matrix_issue_queue #(
  parameter int ENTRIES     = 8,
  parameter int WR_PORTS    = 2,
  parameter int ISSUE_PORTS = 2,
  parameter int WB_WIDTH    = 4,
  parameter int PREG_W      = 6,
  parameter int ROB_W       = 5,
  parameter int PAYLOAD_W   = 32
) (
  input  logic                                   clk,
  input  logic                                   a_rst_n,
  input  logic                                   flush_i,
  input  logic                                   kill_valid_i,
  input  logic                                   kill_pos_i,
  input  logic [ROB_W-1:0]                       kill_rob_i,
  input  logic [WR_PORTS-1:0]                    wr_valid_i,
  output logic                                   wr_ready_o,
  input  logic [WR_PORTS-1:0][PREG_W-1:0]        wr_psrc0_i,
  input  logic [WR_PORTS-1:0][PREG_W-1:0]        wr_psrc1_i,
  input  logic [WR_PORTS-1:0]                    wr_psrc0_valid_i,
  input  logic [WR_PORTS-1:0]                    wr_psrc1_valid_i,
  input  logic [WR_PORTS-1:0]                    wr_psrc0_ready_i,
  input  logic [WR_PORTS-1:0]                    wr_psrc1_ready_i,
  input  logic [WR_PORTS-1:0]                    wr_pos_i,
  input  logic [WR_PORTS-1:0][ROB_W-1:0]         wr_rob_i,
  input  logic [WR_PORTS-1:0][PAYLOAD_W-1:0]     wr_payload_i,
  input  logic [WB_WIDTH-1:0]                    wb_i,
  input  logic [WB_WIDTH-1:0][PREG_W-1:0]        wb_pdest_i,
  output logic [ISSUE_PORTS-1:0]                 issue_valid_o,
  input  logic [ISSUE_PORTS-1:0]                 issue_ready_i,
  output logic [ISSUE_PORTS-1:0][PREG_W-1:0]     issue_psrc0_o,
  output logic [ISSUE_PORTS-1:0][PREG_W-1:0]     issue_psrc1_o,
  output logic [ISSUE_PORTS-1:0]                 issue_pos_o,
  output logic [ISSUE_PORTS-1:0][ROB_W-1:0]      issue_rob_o,
  output logic [ISSUE_PORTS-1:0][PAYLOAD_W-1:0]  issue_payload_o,
  output logic [$clog2(ENTRIES+1)-1:0]           count_o
);

  localparam int CNT_W = $clog2(ENTRIES + 1);
  localparam int IDX_W = $clog2(ENTRIES);

  // True when any active writeback port carries the given tag.
  function automatic logic f_hit(input logic [PREG_W-1:0] tag,
                                 input logic [WB_WIDTH-1:0] en,
                                 input logic [WB_WIDTH-1:0][PREG_W-1:0] pd);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < WB_WIDTH; k++) begin
      if (en[k] && (pd[k] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Strictly younger than the branch; the position bit resolves ROB wrap.
  function automatic logic f_younger(input logic pos, input logic [ROB_W-1:0] rob,
                                     input logic kpos, input logic [ROB_W-1:0] krob);
    return ((pos == kpos) && (rob > krob)) || ((pos != kpos) && (rob < krob));
  endfunction

  // Reset synchroniser: assertion is immediate, release is clocked.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  // Entry state
  logic [ENTRIES-1:0]   r_valid;
  logic [ENTRIES-1:0]   r_p0_v, r_p1_v, r_p0_rdy, r_p1_rdy, r_pos;
  logic [PREG_W-1:0]    r_psrc0   [ENTRIES];
  logic [PREG_W-1:0]    r_psrc1   [ENTRIES];
  logic [ROB_W-1:0]     r_rob     [ENTRIES];
  logic [PAYLOAD_W-1:0] r_payload [ENTRIES];
  logic [ENTRIES-1:0]   r_age     [ENTRIES];  // r_age[i][j]: i older than j
  logic [CNT_W-1:0]     r_count;

  // Combinational helpers
  logic [ENTRIES-1:0]  w_wake0, w_wake1, w_young, w_rdy, w_sel, w_fire;
  logic [ENTRIES-1:0]  w_valid_next;
  logic [CNT_W-1:0]    w_count_next;
  logic [CNT_W-1:0]    w_rank [ENTRIES];
  logic [WR_PORTS-1:0] w_wr_wake0, w_wr_wake1, w_wr_young, w_wr_en;
  logic [IDX_W-1:0]    w_wr_idx [WR_PORTS];

  // Two-flop reset synchroniser
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign count_o    = r_count;
  assign wr_ready_o = (r_count <= CNT_W'(ENTRIES - WR_PORTS));

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign w_wake0[gi] = f_hit(r_psrc0[gi], wb_i, wb_pdest_i);
      assign w_wake1[gi] = f_hit(r_psrc1[gi], wb_i, wb_pdest_i);
      assign w_young[gi] = f_younger(r_pos[gi], r_rob[gi], kill_pos_i, kill_rob_i);
      assign w_rdy[gi]   = r_valid[gi] && (r_p0_rdy[gi] || !r_p0_v[gi]) &&
                           (r_p1_rdy[gi] || !r_p1_v[gi]);
      assign w_sel[gi]   = w_rdy[gi] && !(kill_valid_i && w_young[gi]);
    end
    for (gi = 0; gi < WR_PORTS; gi++) begin : g_wr
      assign w_wr_wake0[gi] = f_hit(wr_psrc0_i[gi], wb_i, wb_pdest_i);
      assign w_wr_wake1[gi] = f_hit(wr_psrc1_i[gi], wb_i, wb_pdest_i);
      assign w_wr_young[gi] = f_younger(wr_pos_i[gi], wr_rob_i[gi], kill_pos_i, kill_rob_i);
      assign w_wr_en[gi]    = !flush_i && wr_ready_o && wr_valid_i[gi] &&
                              !(kill_valid_i && w_wr_young[gi]);
    end
  endgenerate

  // Port k is steered to the k-th lowest free slot of the registered state
  always_comb begin
    int n;
    n = 0;
    for (int k = 0; k < WR_PORTS; k++) w_wr_idx[k] = '0;
    for (int s = 0; s < ENTRIES; s++) begin
      if (!r_valid[s]) begin
        for (int k = 0; k < WR_PORTS; k++) begin
          if (n == k) w_wr_idx[k] = IDX_W'(s);
        end
        n++;
      end
    end
  end

  // Rank of each entry = number of selectable entries older than it
  always_comb begin
    for (int e = 0; e < ENTRIES; e++) begin
      w_rank[e] = '0;
      for (int j = 0; j < ENTRIES; j++) begin
        if ((j != e) && w_sel[j] && r_age[j][e]) w_rank[e] = w_rank[e] + CNT_W'(1);
      end
    end
  end

  // Issue port p presents the selectable entry of rank p
  always_comb begin
    issue_valid_o   = '0;
    issue_psrc0_o   = '0;
    issue_psrc1_o   = '0;
    issue_pos_o     = '0;
    issue_rob_o     = '0;
    issue_payload_o = '0;
    w_fire          = '0;
    for (int p = 0; p < ISSUE_PORTS; p++) begin
      for (int e = 0; e < ENTRIES; e++) begin
        if (w_sel[e] && (w_rank[e] == CNT_W'(p))) begin
          issue_valid_o[p]   = 1'b1;
          issue_psrc0_o[p]   = r_psrc0[e];
          issue_psrc1_o[p]   = r_psrc1[e];
          issue_pos_o[p]     = r_pos[e];
          issue_rob_o[p]     = r_rob[e];
          issue_payload_o[p] = r_payload[e];
          if (issue_ready_i[p]) w_fire[e] = 1'b1;
        end
      end
    end
  end

  // Next valid vector: drop fired and killed entries, add accepted writes
  always_comb begin
    for (int e = 0; e < ENTRIES; e++) begin
      w_valid_next[e] = r_valid[e] && !w_fire[e] && !(kill_valid_i && w_young[e]);
    end
    for (int k = 0; k < WR_PORTS; k++) begin
      if (w_wr_en[k]) w_valid_next[w_wr_idx[k]] = 1'b1;
    end
    if (flush_i) w_valid_next = '0;
    w_count_next = '0;
    for (int e = 0; e < ENTRIES; e++) begin
      w_count_next = w_count_next + CNT_W'(w_valid_next[e]);
    end
  end

  // Valid bits and occupancy are the only state that needs a reset
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_valid_next;
      r_count <= w_count_next;
    end
  end

  // Entry payload, operand readiness (wakeup + dispatch bypass) and age matrix
  always_ff @(posedge clk) begin
    for (int e = 0; e < ENTRIES; e++) begin
      r_p0_rdy[e] <= r_p0_rdy[e] | w_wake0[e];
      r_p1_rdy[e] <= r_p1_rdy[e] | w_wake1[e];
    end
    for (int k = 0; k < WR_PORTS; k++) begin
      if (w_wr_en[k]) begin
        r_psrc0[w_wr_idx[k]]   <= wr_psrc0_i[k];
        r_psrc1[w_wr_idx[k]]   <= wr_psrc1_i[k];
        r_p0_v[w_wr_idx[k]]    <= wr_psrc0_valid_i[k];
        r_p1_v[w_wr_idx[k]]    <= wr_psrc1_valid_i[k];
        r_p0_rdy[w_wr_idx[k]]  <= wr_psrc0_ready_i[k] | w_wr_wake0[k];
        r_p1_rdy[w_wr_idx[k]]  <= wr_psrc1_ready_i[k] | w_wr_wake1[k];
        r_pos[w_wr_idx[k]]     <= wr_pos_i[k];
        r_rob[w_wr_idx[k]]     <= wr_rob_i[k];
        r_payload[w_wr_idx[k]] <= wr_payload_i[k];
        // New entry is younger than everything already resident
        for (int j = 0; j < ENTRIES; j++) begin
          r_age[w_wr_idx[k]][j] <= 1'b0;
          r_age[j][w_wr_idx[k]] <= r_valid[j];
        end
        // Among same-cycle writes the lower port is older; these win over the
        // resident-only defaults written above
        for (int m = 0; m < WR_PORTS; m++) begin
          if (w_wr_en[m] && (m < k)) r_age[w_wr_idx[m]][w_wr_idx[k]] <= 1'b1;
          else if (w_wr_en[m] && (m > k)) r_age[w_wr_idx[k]][w_wr_idx[m]] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_age_matrix_issue_queue.sv
// Directed, table-driven bench for age_matrix_issue_queue. Each table row is one
// clock: inputs are driven after the falling edge, outputs compared 1 time
// unit later (before the rising edge that consumes the row).
module tb_age_matrix_issue_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  a_rst_n;
  logic                  flush_i, kill_valid_i, kill_pos_i;
  logic [4:0]            kill_rob_i;
  logic [1:0]            wr_valid_i;
  logic                  wr_ready_o;
  logic [1:0][5:0]       wr_psrc0_i, wr_psrc1_i;
  logic [1:0]            wr_psrc0_valid_i, wr_psrc1_valid_i, wr_psrc0_ready_i, wr_psrc1_ready_i;
  logic [1:0]            wr_pos_i;
  logic [1:0][4:0]       wr_rob_i;
  logic [1:0][31:0]      wr_payload_i;
  logic [3:0]            wb_i;
  logic [3:0][5:0]       wb_pdest_i;
  logic [1:0]            issue_valid_o, issue_ready_i;
  logic [1:0][5:0]       issue_psrc0_o, issue_psrc1_o;
  logic [1:0]            issue_pos_o;
  logic [1:0][4:0]       issue_rob_o;
  logic [1:0][31:0]      issue_payload_o;
  logic [3:0]            count_o;

  age_matrix_issue_queue dut (
    .clk(clk), .a_rst_n(a_rst_n), .flush_i(flush_i),
    .kill_valid_i(kill_valid_i), .kill_pos_i(kill_pos_i), .kill_rob_i(kill_rob_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_psrc0_i(wr_psrc0_i), .wr_psrc1_i(wr_psrc1_i),
    .wr_psrc0_valid_i(wr_psrc0_valid_i), .wr_psrc1_valid_i(wr_psrc1_valid_i),
    .wr_psrc0_ready_i(wr_psrc0_ready_i), .wr_psrc1_ready_i(wr_psrc1_ready_i),
    .wr_pos_i(wr_pos_i), .wr_rob_i(wr_rob_i), .wr_payload_i(wr_payload_i),
    .wb_i(wb_i), .wb_pdest_i(wb_pdest_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_psrc0_o(issue_psrc0_o), .issue_psrc1_o(issue_psrc1_o),
    .issue_pos_o(issue_pos_o), .issue_rob_o(issue_rob_o),
    .issue_payload_o(issue_payload_o), .count_o(count_o)
  );

  // One clock of stimulus plus the outputs expected during that clock.
  // s0v/s1v: per-port "source used and not yet ready"; tags shared by both ports.
  typedef struct {
    int wv, rob0, rob1, pos, s0v, s0tag, s1v, s1tag;
    int wben, wbport, wbtag, iss, kill, kpos, krob, flush;
    int e_wr, e_cnt, e_iv, e_r0, e_r1;
  } vec_t;

  vec_t vecs[$];
  int checks   = 0;
  int failures = 0;

  function automatic vec_t mkv(int wv, int rob0, int rob1, int pos, int s0v, int s0tag,
                               int s1v, int s1tag, int wben, int wbport, int wbtag, int iss,
                               int kill, int kpos, int krob, int flush,
                               int e_wr, int e_cnt, int e_iv, int e_r0, int e_r1);
    vec_t v;
    v = '{wv, rob0, rob1, pos, s0v, s0tag, s1v, s1tag, wben, wbport, wbtag, iss,
          kill, kpos, krob, flush, e_wr, e_cnt, e_iv, e_r0, e_r1};
    return v;
  endfunction

  task automatic row(int wv, int rob0, int rob1, int pos, int s0v, int s0tag,
                     int s1v, int s1tag, int wben, int wbport, int wbtag, int iss,
                     int kill, int kpos, int krob, int flush,
                     int e_wr, int e_cnt, int e_iv, int e_r0, int e_r1);
    vecs.push_back(mkv(wv, rob0, rob1, pos, s0v, s0tag, s1v, s1tag, wben, wbport, wbtag,
                       iss, kill, kpos, krob, flush, e_wr, e_cnt, e_iv, e_r0, e_r1));
  endtask

  task automatic drive(input vec_t v);
    wr_valid_i          = v.wv[1:0];
    wr_rob_i[0]         = v.rob0[4:0];
    wr_rob_i[1]         = v.rob1[4:0];
    wr_pos_i            = v.pos[1:0];
    wr_psrc0_i[0]       = v.s0tag[5:0];
    wr_psrc0_i[1]       = v.s0tag[5:0];
    wr_psrc1_i[0]       = v.s1tag[5:0];
    wr_psrc1_i[1]       = v.s1tag[5:0];
    wr_psrc0_valid_i    = v.s0v[1:0];
    wr_psrc1_valid_i    = v.s1v[1:0];
    wr_psrc0_ready_i    = 2'b00;
    wr_psrc1_ready_i    = 2'b00;
    wr_payload_i[0]     = 32'hC0DE_0000 | 32'(v.rob0);
    wr_payload_i[1]     = 32'hC0DE_0000 | 32'(v.rob1);
    wb_i                = '0;
    wb_pdest_i          = '0;
    if (v.wben != 0) begin
      wb_i[v.wbport[1:0]]       = 1'b1;
      wb_pdest_i[v.wbport[1:0]] = v.wbtag[5:0];
    end
    issue_ready_i       = v.iss[1:0];
    kill_valid_i        = v.kill[0];
    kill_pos_i          = v.kpos[0];
    kill_rob_i          = v.krob[4:0];
    flush_i             = v.flush[0];
  endtask

  task automatic idle();
    vec_t z;
    z = mkv(0,0,0,0, 0,0,0,0, 0,0,0, 0, 0,0,0,0, 0,0,0,0,0);
    drive(z);
  endtask

  task automatic check(input string nm, input int r, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h expected=%0h", nm, r, got, exp);
    end
  endtask

  initial begin
    a_rst_n = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_count", -1, 32'(count_o), 32'd0);
    check("rst_wr_ready", -1, 32'(wr_ready_o), 32'd1);
    check("rst_issue_valid", -1, 32'(issue_valid_o), 32'd0);
    a_rst_n = 1'b1;
    repeat (3) @(posedge clk);

    //   wv rob0 rob1 pos s0v tag s1v tag wben port tag iss kill kpos krob flush | wr cnt iv r0 r1
    // two ready ops, issue both together
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);
    row(3,  3, 4, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  3,  0,0,0,  0,   1,2,3,3,4);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);
    // A waits on tag 9, B ready; wakeup via wb port 1
    row(3,  5, 6, 0,  1, 9, 0, 0,   0,0,0,  3,  0,0,0,  0,   1,0,0,0,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  3,  0,0,0,  0,   1,2,1,6,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   1,1,9,  3,  0,0,0,  0,   1,1,0,0,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  3,  0,0,0,  0,   1,1,1,5,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);
    // same-cycle bypass on psrc1 = 12
    row(1,  7, 0, 0,  0, 0, 1,12,   1,0,12, 3,  0,0,0,  0,   1,0,0,0,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  3,  0,0,0,  0,   1,1,1,7,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);
    // kill across ROB wrap: rob30/pos0 survives, rob1/rob2 (pos1) and incoming rob5 die
    row(3, 30, 1, 2,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);
    row(1,  2, 0, 1,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,2,3,30,1);
    row(1,  5, 0, 1,  0, 0, 0, 0,   0,0,0,  0,  1,0,31, 0,   1,3,1,30,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,1,1,30,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  3,  0,0,0,  0,   1,1,1,30,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);
    // partial issue, re-rank, reused low slot stays youngest, flush beats writes
    row(3, 10,11, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);
    row(1, 12, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,2,3,10,11);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  1,  0,0,0,  0,   1,3,3,10,11);
    row(1, 15, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,2,3,11,12);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,3,3,11,12);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  3,  0,0,0,  0,   1,3,3,11,12);
    row(3, 13,14, 0,  0, 0, 0, 0,   0,0,0,  3,  0,0,0,  1,   1,1,1,15,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);
    // non-contiguous dispatch: only port 1 valid
    row(2,  0,20, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  1,  0,0,0,  0,   1,1,1,20,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);
    // fill to 8 with ops waiting on tag 40, full back-pressure, frees seen a cycle late
    row(3,  0, 1, 0,  3,40, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);
    row(3,  2, 3, 0,  3,40, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,2,0,0,0);
    row(3,  4, 5, 0,  3,40, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,4,0,0,0);
    row(3,  6, 7, 0,  3,40, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,6,0,0,0);
    row(3,  8, 9, 0,  3,40, 0, 0,   1,2,40, 0,  0,0,0,  0,   0,8,0,0,0);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  3,  0,0,0,  0,   0,8,3,0,1);
    row(1, 10, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,6,3,2,3);
    row(3, 11,12, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   0,7,3,2,3);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  1,   0,7,3,2,3);
    row(0,  0, 0, 0,  0, 0, 0, 0,   0,0,0,  0,  0,0,0,  0,   1,0,0,0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check("wr_ready", i, 32'(wr_ready_o), 32'(vecs[i].e_wr));
      check("count", i, 32'(count_o), 32'(vecs[i].e_cnt));
      check("issue_valid", i, 32'(issue_valid_o), 32'(vecs[i].e_iv));
      if (vecs[i].e_iv[0]) begin
        check("issue_rob0", i, 32'(issue_rob_o[0]), 32'(vecs[i].e_r0));
        check("issue_payload0", i, issue_payload_o[0], 32'hC0DE_0000 | 32'(vecs[i].e_r0));
      end
      if (vecs[i].e_iv[1]) begin
        check("issue_rob1", i, 32'(issue_rob_o[1]), 32'(vecs[i].e_r1));
      end
      $display("row %0d: wv=%0d iss=%0d kill=%0d flush=%0d -> cnt=%0d wr_ready=%0d iv=%0d rob0=%0d rob1=%0d",
               i, vecs[i].wv, vecs[i].iss, vecs[i].kill, vecs[i].flush,
               count_o, wr_ready_o, issue_valid_o, issue_rob_o[0], issue_rob_o[1]);
    end

    // Reset asserted mid-operation clears state without waiting for a clock
    @(negedge clk);
    drive(mkv(3,1,2,0, 0,0,0,0, 0,0,0, 0, 0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    idle();
    #1;
    check("mid_count_before", 100, 32'(count_o), 32'd2);
    check("mid_iv_before", 100, 32'(issue_valid_o), 32'd3);
    a_rst_n = 1'b0;
    #1;
    check("mid_count_async", 101, 32'(count_o), 32'd0);
    check("mid_iv_async", 101, 32'(issue_valid_o), 32'd0);
    check("mid_wr_ready_async", 101, 32'(wr_ready_o), 32'd1);
    @(negedge clk);
    a_rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    drive(mkv(1,5,0,0, 0,0,0,0, 0,0,0, 0, 0,0,0,0, 0,0,0,0,0));
    @(negedge clk);
    idle();
    #1;
    check("post_rst_count", 102, 32'(count_o), 32'd1);
    check("post_rst_iv", 102, 32'(issue_valid_o), 32'd1);
    check("post_rst_rob0", 102, 32'(issue_rob_o[0]), 32'd5);
    $display("mid-reset sequence: cnt=%0d iv=%0d rob0=%0d", count_o, issue_valid_o, issue_rob_o[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/age_matrix_issue_queue.md
# age_matrix_issue_queue

Unified, parametrised reservation station that replaces per-bank fixed-oldest selection with a true age matrix. It accepts up to WR_PORTS dispatched micro-ops per cycle and wakes source operands from the writeback bus, including same-cycle wakeup of incoming micro-ops. Each cycle it issues up to ISSUE_PORTS ready micro-ops, oldest first. It supports full flush and partial (branch) kill of entries younger than a given ROB tag, and sits between dispatch and one homogeneous group of functional units.

## Interface
- ENTRIES, 8: queue depth (≥ WR_PORTS, ≥ 2).
- WR_PORTS, 2: dispatch ports per cycle.
- ISSUE_PORTS, 2: issue ports per cycle (≤ ENTRIES).
- WB_WIDTH, 4: writeback/wakeup ports.
- PREG_W, 6: physical register tag width.
- ROB_W, 5: ROB index width (excludes position bit).
- PAYLOAD_W, 32: opaque micro-op payload (option code + immediates), passed through untouched.
- clk  in  1  clock.
- a_rst_n  in  1  asynchronous active-low reset, synchronised internally with the codebase reset macro.
- flush_i  in  1  synchronous full flush.
- kill_valid_i  in  1  partial kill request.
- kill_pos_i / kill_rob_i  in  1 / ROB_W  position bit and ROB index of the branch; strictly younger entries die.
- wr_valid_i  in  WR_PORTS  per-port dispatch valid.
- wr_ready_o  out  1  all WR_PORTS may write this cycle.
- wr_psrc0_i, wr_psrc1_i  in  WR_PORTS×PREG_W  source tags.
- wr_psrc0_valid_i, wr_psrc1_valid_i, wr_psrc0_ready_i, wr_psrc1_ready_i  in  WR_PORTS  source used / already ready.
- wr_pos_i, wr_rob_i  in  WR_PORTS×1 / ×ROB_W  age tag.
- wr_payload_i  in  WR_PORTS×PAYLOAD_W.
- wb_i  in  WB_WIDTH; wb_pdest_i  in  WB_WIDTH×PREG_W  wakeup tags.
- issue_valid_o  out  ISSUE_PORTS; issue_ready_i  in  ISSUE_PORTS.
- issue_psrc0_o, issue_psrc1_o, issue_pos_o, issue_rob_o, issue_payload_o  out  per issue port.
- count_o  out  $clog2(ENTRIES+1)  registered occupancy.

## Operation
- Entry state: valid, psrc{0,1}, psrc{0,1}_valid, psrc{0,1}_ready, pos, rob, payload; plus age matrix age[i][j] (1 = i older than j), ENTRIES×ENTRIES bits.
- Ready entry: valid && (psrc0_ready || !psrc0_valid) && (psrc1_ready || !psrc1_valid).
- Dispatch: wr_ready_o = (ENTRIES − count_o) ≥ WR_PORTS, from registered state only. A write occurs when wr_valid_i[k] && wr_ready_o. Valid ports need not be contiguous. Port k takes the k-th lowest-index free slot in registered state.
- Age update on write to slot s: age[j][s]=1 for every currently valid j; age[s][j]=0 for them; among same-cycle writes, lower port is older.
- Wakeup: for each valid entry and each incoming write, a psrc matching any wb_pdest_i[k] with wb_i[k] sets its ready bit. Incoming writes are matched in the same cycle (bypass), so the stored entry is already ready.
- Select: rank(e) = popcount over ready entries older than e. Issue port p presents the ready entry with rank p, and issue_valid_o[p]=0 if fewer than p+1 ready entries exist. Ports are independent: fire = valid && ready. A fired entry is invalidated at the next edge; a non-fired one stays and is re-ranked.
- Kill: entry is younger iff (pos==kill_pos && rob>kill_rob) || (pos!=kill_pos && rob<kill_rob). While kill_valid_i is high, younger entries are masked from select, and they and younger incoming writes are dropped at the edge.
- flush_i: all entries invalid at the next edge; overrides writes, wakeups and issues.
- count_o = registered number of valid entries.

## Timing
- Reset (and after flush): all entries invalid, count_o=0, wr_ready_o=1, issue_valid_o=0. Age matrix don't-care when invalid.
- Dispatch to earliest issue: 1 cycle (written at edge, selectable next cycle).
- Wakeup to issue: 1 cycle. Issue outputs combinational from registered state plus kill_valid_i masking only.
- A slot freed by issue or kill becomes writable one cycle later; wr_ready_o never sees same-cycle frees.
- Full: count_o > ENTRIES−WR_PORTS → wr_ready_o=0; writes ignored.
- ROB index wrap is handled only by the position bit in kill. Issue ordering uses the age matrix, never ROB compare.
- Reset mid-operation clears all state asynchronously; outputs take reset values immediately.

## Test plan
- Reset → count_o=0, wr_ready_o=1, issue_valid_o=00. Write two ready ops (rob 3, rob 4) in one cycle → next cycle port0 rob 3, port1 rob 4; both fire → count_o 2→0.
- Write op A (psrc0=9 not ready) then B (ready). Next cycle only B issues on port0. Then wb_i[1]=1 with pdest 9 → A issues one cycle later.
- Dispatch op with psrc1=12 not ready while wb_pdest_i[0]=12 valid → issues on port0 the very next cycle.
- Fill 8 entries → wr_ready_o=0 at count 7 and 8. Issue 2 with issue_ready_i=11 → wr_ready_o=1 the following cycle, not the same cycle.
- Entries at rob 30 (pos 0), 1 and 2 (pos 1); kill pos 0 rob 31 → rob 30 survives, 1 and 2 masked at once and gone next cycle, count_o=1.
- issue_ready_i=01 with 3 ready ops → oldest leaves. Second-oldest stays and moves to port0 next cycle. flush_i during writes → count_o=0, no write lands.
